// File: rtl/camera_param_ctrl_if.sv
// Request/ack bundle for the host and calibration requesters plus the parameter-bank write port.
interface camera_param_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic              h_req;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    logic              h_last;
    logic              h_ack;

    logic              c_req;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic              c_last;
    logic              c_ack;

    logic [ADDR_W-1:0] param_addr;
    logic [DATA_W-1:0] param_data;
    logic              wr_en;
    logic              busy;
    logic              update_done;

    // Requester side: drives requests, observes acks and bank traffic.
    modport master (
        output h_req, h_addr, h_data, h_last,
        output c_req, c_addr, c_data, c_last,
        input  h_ack, c_ack,
        input  param_addr, param_data, wr_en, busy, update_done
    );

    // Controller side.
    modport slave (
        input  h_req, h_addr, h_data, h_last,
        input  c_req, c_addr, c_data, c_last,
        output h_ack, c_ack,
        output param_addr, param_data, wr_en, busy, update_done
    );
endinterface

// File: rtl/camera_param_ctrl.sv
// Round-robin burst arbiter sharing the camera parameter bank write port; every burst ends in a flush.
// Optional write-lock feature enabled by defining CAM_PARAM_LOCK_EN (adds lock_i / err_o).
module camera_param_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 8,
    parameter int IDLE_TMO  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef CAM_PARAM_LOCK_EN
    input  logic                lock_i,
    output logic                err_o,
`endif
    camera_param_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WRITE, FLUSH, DONE} state_e;

    localparam logic [7:0] BMAX = 8'(BURST_MAX);
    localparam logic [7:0] TMO  = 8'(IDLE_TMO);
`ifdef CAM_PARAM_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    state_e            state_q;
    logic              owner_q;   // 0 = host, 1 = calibration
    logic              prio_q;    // side that wins a simultaneous request
    logic [7:0]        cnt_q;
    logic [7:0]        tmo_q;
    logic              close_q;   // burst ends once the pending ack cycle retires
    logic              wrote_q;   // at least one word of this burst reached the bank
    logic              h_ack_q, c_ack_q, wr_en_q, busy_q, upd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
`ifdef CAM_PARAM_LOCK_EN
    logic              err_q;
`endif

    logic              own_req, own_last, own_ack, lock_w, flush_ok;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_data;

    always_comb begin
        own_req  = owner_q ? bus.c_req  : bus.h_req;
        own_last = owner_q ? bus.c_last : bus.h_last;
        own_addr = owner_q ? bus.c_addr : bus.h_addr;
        own_data = owner_q ? bus.c_data : bus.h_data;
        own_ack  = owner_q ? c_ack_q    : h_ack_q;
    end

`ifdef CAM_PARAM_LOCK_EN
    assign lock_w = lock_i;
    assign err_o  = err_q;
`else
    assign lock_w = 1'b0;
`endif

    // A fully locked burst has nothing to make coherent, so it skips the flush.
    assign flush_ok = wrote_q | ~LOCK_EN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            close_q <= 1'b0;
            wrote_q <= 1'b0;
            h_ack_q <= 1'b0;
            c_ack_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            upd_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef CAM_PARAM_LOCK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            h_ack_q <= 1'b0;
            c_ack_q <= 1'b0;
            wr_en_q <= 1'b0;
            upd_q   <= 1'b0;
`ifdef CAM_PARAM_LOCK_EN
            err_q   <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (bus.h_req || bus.c_req) begin
                        owner_q <= (bus.h_req && bus.c_req) ? prio_q : bus.c_req;
                        state_q <= WRITE;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        tmo_q   <= '0;
                        close_q <= 1'b0;
                        wrote_q <= 1'b0;
                    end
                end
                WRITE: begin
                    if (close_q) begin
                        close_q <= 1'b0;
                        if (flush_ok) begin
                            state_q <= FLUSH;
                            wr_en_q <= 1'b1;
                        end else begin
                            state_q <= DONE;
                        end
                    end else if (own_req && !own_ack) begin
                        h_ack_q <= ~owner_q;
                        c_ack_q <= owner_q;
                        tmo_q   <= '0;
                        cnt_q   <= cnt_q + 8'd1;
                        if (own_last || (cnt_q + 8'd1 == BMAX))
                            close_q <= 1'b1;
                        if (lock_w) begin
`ifdef CAM_PARAM_LOCK_EN
                            err_q <= 1'b1;
`endif
                        end else begin
                            wr_en_q <= 1'b1;
                            addr_q  <= own_addr;
                            data_q  <= own_data;
                            wrote_q <= 1'b1;
                        end
                    end else if (!own_req) begin
                        // Owner went quiet mid-burst: close it out after IDLE_TMO cycles.
                        tmo_q <= tmo_q + 8'd1;
                        if (tmo_q + 8'd1 == TMO) begin
                            if (flush_ok) begin
                                state_q <= FLUSH;
                                wr_en_q <= 1'b1;
                            end else begin
                                state_q <= DONE;
                            end
                        end
                    end
                end
                FLUSH: begin
                    state_q <= DONE;
                    upd_q   <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    prio_q  <= ~owner_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.h_ack       = h_ack_q;
    assign bus.c_ack       = c_ack_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.param_addr  = addr_q;
    assign bus.param_data  = data_q;
    assign bus.busy        = busy_q;
    assign bus.update_done = upd_q;

endmodule

// File: tb/tb_camera_param_ctrl.sv
// Directed bench for camera_param_ctrl: bursts, round-robin, burst cap, idle timeout, reset, lock.
module tb_camera_param_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    camera_param_ctrl_if #(.ADDR_W(3), .DATA_W(32)) bif ();

`ifdef CAM_PARAM_LOCK_EN
    logic lock = 1'b0;
    logic err;
    camera_param_ctrl #(.ADDR_W(3), .DATA_W(32), .BURST_MAX(8), .IDLE_TMO(16)) dut (
        .clk(clk), .rst_n(rst_n), .lock_i(lock), .err_o(err), .bus(bif));
`else
    camera_param_ctrl #(.ADDR_W(3), .DATA_W(32), .BURST_MAX(8), .IDLE_TMO(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic drive_h(input logic [2:0] a, input logic [31:0] d, input logic l);
        bif.h_req = 1'b1; bif.h_addr = a; bif.h_data = d; bif.h_last = l;
    endtask

    task automatic drive_c(input logic [2:0] a, input logic [31:0] d, input logic l);
        bif.c_req = 1'b1; bif.c_addr = a; bif.c_data = d; bif.c_last = l;
    endtask

    // Word driven at the current negedge: one quiet cycle, then the write + ack.
    task automatic wait_ack(input string tag, input bit cal, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chk({tag, " gap wr_en"}, 32'(bif.wr_en), 0);
        chk({tag, " gap h_ack"}, 32'(bif.h_ack), 0);
        chk({tag, " gap c_ack"}, 32'(bif.c_ack), 0);
        @(negedge clk);
        chk({tag, " wr_en"}, 32'(bif.wr_en), 1);
        chk({tag, " addr"}, 32'(bif.param_addr), 32'(a));
        chk({tag, " data"}, bif.param_data, d);
        chk({tag, " h_ack"}, 32'(bif.h_ack), 32'(!cal));
        chk({tag, " c_ack"}, 32'(bif.c_ack), 32'(cal));
        chk({tag, " busy"}, 32'(bif.busy), 1);
    endtask

    // After the final ack: flush rewrite, update_done, then idle.
    task automatic close_chk(input string tag, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chk({tag, " flush wr_en"}, 32'(bif.wr_en), 1);
        chk({tag, " flush addr"}, 32'(bif.param_addr), 32'(a));
        chk({tag, " flush data"}, bif.param_data, d);
        chk({tag, " flush acks"}, {30'd0, bif.h_ack, bif.c_ack}, 0);
        chk({tag, " flush upd"}, 32'(bif.update_done), 0);
        @(negedge clk);
        chk({tag, " done upd"}, 32'(bif.update_done), 1);
        chk({tag, " done wr_en"}, 32'(bif.wr_en), 0);
        chk({tag, " done busy"}, 32'(bif.busy), 1);
        @(negedge clk);
        chk({tag, " idle busy"}, 32'(bif.busy), 0);
        chk({tag, " idle upd"}, 32'(bif.update_done), 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " wr_en"}, 32'(bif.wr_en), 0);
        chk({tag, " acks"}, {30'd0, bif.h_ack, bif.c_ack}, 0);
        chk({tag, " busy"}, 32'(bif.busy), 0);
        chk({tag, " upd"}, 32'(bif.update_done), 0);
        chk({tag, " addr"}, 32'(bif.param_addr), 0);
        chk({tag, " data"}, bif.param_data, 0);
    endtask

    initial begin
        bif.h_req = 0; bif.h_addr = 0; bif.h_data = 0; bif.h_last = 0;
        bif.c_req = 0; bif.c_addr = 0; bif.c_data = 0; bif.c_last = 0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: three-word host burst
        drive_h(3'd0, 32'h578, 1'b0);
        wait_ack("t1 w0", 1'b0, 3'd0, 32'h578);
        drive_h(3'd1, 32'h578, 1'b0);
        wait_ack("t1 w1", 1'b0, 3'd1, 32'h578);
        drive_h(3'd2, 32'h280, 1'b1);
        wait_ack("t1 w2", 1'b0, 3'd2, 32'h280);
        bif.h_req = 1'b0;
        close_chk("t1", 3'd2, 32'h280);

        // 2: simultaneous requests after reset -> host then cal
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_h(3'd3, 32'h1111_0003, 1'b1);
        drive_c(3'd6, 32'h2222_0006, 1'b1);
        wait_ack("t2 h", 1'b0, 3'd3, 32'h1111_0003);
        bif.h_req = 1'b0;
        close_chk("t2 h", 3'd3, 32'h1111_0003);
        wait_ack("t2 c", 1'b1, 3'd6, 32'h2222_0006);
        bif.c_req = 1'b0;
        close_chk("t2 c", 3'd6, 32'h2222_0006);
        // host-only burst leaves priority with cal; then both together -> cal first
        drive_h(3'd7, 32'h3333_0007, 1'b1);
        wait_ack("t2 h2", 1'b0, 3'd7, 32'h3333_0007);
        bif.h_req = 1'b0;
        close_chk("t2 h2", 3'd7, 32'h3333_0007);
        drive_h(3'd1, 32'h4444_0001, 1'b1);
        drive_c(3'd2, 32'h5555_0002, 1'b1);
        wait_ack("t2 rr c", 1'b1, 3'd2, 32'h5555_0002);
        bif.c_req = 1'b0;
        close_chk("t2 rr c", 3'd2, 32'h5555_0002);
        wait_ack("t2 rr h", 1'b0, 3'd1, 32'h4444_0001);
        bif.h_req = 1'b0;
        close_chk("t2 rr h", 3'd1, 32'h4444_0001);

        // 3: 10-word cal burst split by the 8-word cap
        drive_c(3'd0, 32'hCA10_0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            wait_ack($sformatf("t3 w%0d", i), 1'b1, 3'(i), 32'hCA10_0000 + 32'(i));
            if (i < 9) drive_c(3'(i + 1), 32'hCA10_0000 + 32'(i + 1), (i == 8));
            else bif.c_req = 1'b0;
            if (i == 7) close_chk("t3 cap", 3'd7, 32'hCA10_0007);
        end
        close_chk("t3 end", 3'd1, 32'hCA10_0009);

        // 4: host drops req mid-burst -> flush IDLE_TMO cycles after the ack
        drive_h(3'd4, 32'hFFFF_FC18, 1'b0);
        wait_ack("t4 w", 1'b0, 3'd4, 32'hFFFF_FC18);
        bif.h_req = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("t4 wait%0d wr_en", k), 32'(bif.wr_en), 0);
            chk($sformatf("t4 wait%0d busy", k), 32'(bif.busy), 1);
        end
        close_chk("t4", 3'd4, 32'hFFFF_FC18);

        // 5: reset mid-burst, then both request -> host wins again
        drive_h(3'd5, 32'hAAAA_0005, 1'b0);
        wait_ack("t5 w0", 1'b0, 3'd5, 32'hAAAA_0005);
        drive_h(3'd6, 32'hAAAA_0006, 1'b0);
        wait_ack("t5 w1", 1'b0, 3'd6, 32'hAAAA_0006);
        drive_h(3'd0, 32'hBBBB_0000, 1'b1);
        drive_c(3'd3, 32'hCCCC_0003, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("t5 rst");
        @(negedge clk);
        chk_reset_outs("t5 rst hold");
        rst_n = 1'b1;
        wait_ack("t5 h", 1'b0, 3'd0, 32'hBBBB_0000);
        bif.h_req = 1'b0;
        close_chk("t5 h", 3'd0, 32'hBBBB_0000);
        wait_ack("t5 c", 1'b1, 3'd3, 32'hCCCC_0003);
        bif.c_req = 1'b0;
        close_chk("t5 c", 3'd3, 32'hCCCC_0003);

`ifdef CAM_PARAM_LOCK_EN
        // 6: locked single-word burst is acked with err and never written
        lock = 1'b1;
        drive_h(3'd5, 32'h0000_1234, 1'b1);
        @(negedge clk);
        chk("t6 gap ack", 32'(bif.h_ack), 0);
        @(negedge clk);
        chk("t6 h_ack", 32'(bif.h_ack), 1);
        chk("t6 err", 32'(err), 1);
        chk("t6 wr_en", 32'(bif.wr_en), 0);
        bif.h_req = 1'b0;
        @(negedge clk);
        chk("t6 done wr_en", 32'(bif.wr_en), 0);
        chk("t6 done upd", 32'(bif.update_done), 0);
        chk("t6 done err", 32'(err), 0);
        @(negedge clk);
        chk("t6 idle busy", 32'(bif.busy), 0);
        chk("t6 idle upd", 32'(bif.update_done), 0);
        chk("t6 idle wr_en", 32'(bif.wr_en), 0);
        lock = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
